// File: rtl/udi_spect_peak.sv
// udi_spect_peak: integrates 2^K frames of spectral power bins, then scans the
// averaged bins for the peak value/index and the count of bins above threshold.
module udi_spect_peak #(
  parameter int NBINS     = 16,
  parameter int LOG_NBINS = 4,
  parameter int ACCW      = 35
) (
  input  logic                 gclk,
  input  logic                 greset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [31:0]          in_pwr,
  output logic                 in_ready,
  input  logic [1:0]           cfg_avg_log2,
  input  logic [31:0]          in_thr,
  output logic                 out_valid,
  output logic [31:0]          out_peak_pwr,
  output logic [LOG_NBINS-1:0] out_peak_idx,
  output logic [LOG_NBINS:0]   out_hit_cnt,
  output logic                 out_err
);

  localparam int DATA_W = 32;
  localparam int HIT_W  = LOG_NBINS + 1;
  localparam logic [LOG_NBINS-1:0] LAST_BIN = LOG_NBINS'(NBINS - 1);

  typedef enum logic [1:0] {IDLE, ACC, SCAN, DONE} state_t;

  // Averaging is a truncating right shift of the integrated power.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACCW-1:0] a,
                                                  input logic [1:0] sh);
    return DATA_W'(a >> sh);
  endfunction

  state_t                state, nxt_state;
  logic [LOG_NBINS-1:0]  bin_cnt;
  logic [2:0]            frame_cnt;
  logic [1:0]            avg_log2_r;
  logic [LOG_NBINS-1:0]  scan_idx;
  logic [ACCW-1:0]       acc [NBINS];

  logic [DATA_W-1:0]     thr_r;
  logic [DATA_W-1:0]     peak;
  logic [LOG_NBINS-1:0]  pk_idx;
  logic [HIT_W-1:0]      hit;

  logic                  accept, start, acc_wr, err, frame_last, scan_done;
  logic [2:0]            frames_m1;
  logic [ACCW-1:0]       pwr_ext;
  logic [DATA_W-1:0]     avg_s;
  logic [DATA_W-1:0]     peak_nxt;
  logic [LOG_NBINS-1:0]  idx_nxt;
  logic [HIT_W-1:0]      hit_nxt;

  assign in_ready   = (state == IDLE) || (state == ACC);
  assign accept     = in_valid && in_ready;
  assign pwr_ext    = ACCW'(in_pwr);
  assign frames_m1  = ~(3'b111 << avg_log2_r);
  assign frame_last = (bin_cnt == LAST_BIN) && (frame_cnt == frames_m1);
  assign scan_done  = (state == SCAN) && (scan_idx == LAST_BIN);

  // Scan datapath: fold the current averaged bin into the running peak/hit
  assign avg_s    = avg_trunc(acc[scan_idx], avg_log2_r);
  assign peak_nxt = (avg_s > peak) ? avg_s : peak;
  assign idx_nxt  = (avg_s > peak) ? scan_idx : pk_idx;
  assign hit_nxt  = hit + HIT_W'(avg_s > thr_r);

  // Next-state and per-sample control decode
  always_comb begin
    nxt_state = state;
    start     = 1'b0;
    acc_wr    = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (accept && in_sof) begin
          start     = 1'b1;
          nxt_state = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (in_sof && (bin_cnt != '0)) begin
            err       = 1'b1;
            start     = 1'b1;
            nxt_state = ACC;
          end else if (!in_sof && (bin_cnt == '0)) begin
            err       = 1'b1;
            nxt_state = IDLE;
          end else begin
            acc_wr = 1'b1;
            if (frame_last) nxt_state = SCAN;
          end
        end
      end
      SCAN: begin
        if (scan_idx == LAST_BIN) nxt_state = DONE;
      end
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Control state: FSM, counters, latched config and result registers
  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      state        <= IDLE;
      bin_cnt      <= '0;
      frame_cnt    <= '0;
      avg_log2_r   <= '0;
      scan_idx     <= '0;
      out_valid    <= 1'b0;
      out_err      <= 1'b0;
      out_peak_pwr <= '0;
      out_peak_idx <= '0;
      out_hit_cnt  <= '0;
    end else begin
      state   <= nxt_state;
      out_err <= err;
      if (start) begin
        bin_cnt    <= LOG_NBINS'(1);
        frame_cnt  <= '0;
        avg_log2_r <= cfg_avg_log2;
      end else if (acc_wr) begin
        bin_cnt <= bin_cnt + LOG_NBINS'(1);
        if (bin_cnt == LAST_BIN) frame_cnt <= frame_cnt + 3'd1;
      end else if (err) begin
        bin_cnt   <= '0;
        frame_cnt <= '0;
      end
      scan_idx  <= (state == SCAN) ? scan_idx + LOG_NBINS'(1) : '0;
      // Result is registered on the last scan step so it is visible in DONE
      out_valid <= scan_done;
      if (scan_done) begin
        out_peak_pwr <= peak_nxt;
        out_peak_idx <= idx_nxt;
        out_hit_cnt  <= hit_nxt;
      end
    end
  end

  // Datapath: accumulator writes and scan working registers (no reset needed)
  always_ff @(posedge gclk) begin
    if (start) begin
      acc[0] <= pwr_ext;
    end else if (acc_wr) begin
      acc[bin_cnt] <= (frame_cnt == 3'd0) ? pwr_ext : acc[bin_cnt] + pwr_ext;
    end
    if ((state == ACC) && (nxt_state == SCAN)) begin
      thr_r  <= in_thr;
      peak   <= '0;
      pk_idx <= '0;
      hit    <= '0;
    end else if (state == SCAN) begin
      peak   <= peak_nxt;
      pk_idx <= idx_nxt;
      hit    <= hit_nxt;
    end
  end

endmodule

// File: tb/tb_udi_spect_peak.sv
// Directed testbench for udi_spect_peak with hand-computed expected results.
module tb_udi_spect_peak;

  logic        gclk = 1'b0;
  logic        greset;
  logic        in_valid, in_sof, in_ready;
  logic [31:0] in_pwr, in_thr;
  logic [1:0]  cfg_avg_log2;
  logic        out_valid, out_err;
  logic [31:0] out_peak_pwr;
  logic [3:0]  out_peak_idx;
  logic [4:0]  out_hit_cnt;

  int checks = 0;
  int failures = 0;

  // Monitor state (written only by the monitor process)
  int cyc = 0, last_acc = 0, v_cyc = 0, vcnt = 0, ecnt = 0, nr_cnt = 0, acnt = 0;
  logic [31:0] cap_pwr;
  logic [3:0]  cap_idx;
  logic [4:0]  cap_hit;

  logic [31:0] fr [16];

  udi_spect_peak #(.NBINS(16), .LOG_NBINS(4), .ACCW(35)) dut (
    .gclk(gclk), .greset(greset), .in_valid(in_valid), .in_sof(in_sof),
    .in_pwr(in_pwr), .in_ready(in_ready), .cfg_avg_log2(cfg_avg_log2),
    .in_thr(in_thr), .out_valid(out_valid), .out_peak_pwr(out_peak_pwr),
    .out_peak_idx(out_peak_idx), .out_hit_cnt(out_hit_cnt), .out_err(out_err)
  );

  always #5 gclk = ~gclk;

  // Sample everything on the falling edge
  always @(negedge gclk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      last_acc <= cyc;
      acnt     <= acnt + 1;
    end
    if (out_valid) begin
      vcnt    <= vcnt + 1;
      v_cyc   <= cyc;
      cap_pwr <= out_peak_pwr;
      cap_idx <= out_peak_idx;
      cap_hit <= out_hit_cnt;
    end
    if (out_err) ecnt <= ecnt + 1;
    if (!in_ready) nr_cnt <= nr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic send(input bit sof, input logic [31:0] pwr, input int gaps);
    in_valid = 1'b0;
    repeat (gaps) tick();
    in_valid = 1'b1;
    in_sof   = sof;
    in_pwr   = pwr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gapmax);
    for (int i = 0; i < 16; i++)
      send(i == 0, fr[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic wait_res(input string tag, input int v0, input logic [31:0] ep,
                          input logic [3:0] ei, input logic [4:0] eh);
    int n = 0;
    while (vcnt == v0 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, vcnt - v0, 1);
    check({tag, "_pwr"}, cap_pwr, ep);
    check({tag, "_idx"}, cap_idx, ei);
    check({tag, "_hit"}, cap_hit, eh);
  endtask

  initial begin
    int v0, e0, n0, a0;
    greset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pwr = '0;
    in_thr = '0; cfg_avg_log2 = '0;
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_vld", out_valid, 0);
    check("rst_err", out_err, 0);
    check("rst_pwr", out_peak_pwr, 0);
    check("rst_hit", out_hit_cnt, 0);
    repeat (3) tick();
    greset = 1'b0;
    tick();

    // Single frame, ramp 10*bin, back-to-back
    for (int i = 0; i < 16; i++) fr[i] = 32'(10 * i);
    in_thr = 75; cfg_avg_log2 = 0;
    v0 = vcnt; n0 = nr_cnt;
    send_frame(0);
    wait_res("ramp", v0, 150, 15, 8);
    check("ramp_lat", v_cyc - last_acc, 17);
    repeat (3) tick();
    check("ramp_notready", nr_cnt - n0, 17);
    check("ramp_onepulse", vcnt - v0, 1);

    // Four frames with gaps, single peak
    for (int i = 0; i < 16; i++) fr[i] = 100;
    fr[5] = 1000;
    in_thr = 500; cfg_avg_log2 = 2;
    v0 = vcnt;
    repeat (4) send_frame(2);
    cfg_avg_log2 = 0;
    wait_res("avg4", v0, 1000, 5, 1);

    // Tie: lowest index wins
    for (int i = 0; i < 16; i++) fr[i] = 100;
    fr[3] = 1000; fr[9] = 1000;
    cfg_avg_log2 = 2;
    v0 = vcnt;
    repeat (4) send_frame(1);
    wait_res("tie", v0, 1000, 3, 2);

    // Full-scale over 8 frames, no wrap
    for (int i = 0; i < 16; i++) fr[i] = 32'hFFFF_FFFF;
    in_thr = 0; cfg_avg_log2 = 3;
    v0 = vcnt;
    repeat (8) send_frame(0);
    wait_res("full", v0, 32'hFFFF_FFFF, 0, 16);

    // 7,0,0,... over 8 frames
    for (int i = 0; i < 16; i++) fr[i] = 0;
    fr[0] = 7;
    v0 = vcnt;
    repeat (8) send_frame(0);
    wait_res("seven", v0, 7, 0, 1);

    // Truncating shift and strict threshold: (5+4)>>1=4, (3+2)>>1=2 with thr=2
    for (int i = 0; i < 16; i++) fr[i] = 0;
    cfg_avg_log2 = 1; in_thr = 2;
    v0 = vcnt;
    fr[4] = 5; fr[6] = 3;
    send_frame(0);
    fr[4] = 4; fr[6] = 2;
    send_frame(0);
    wait_res("trunc", v0, 4, 4, 1);

    // Early SOF at bin 7 restarts the frame
    cfg_avg_log2 = 0; in_thr = 20;
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 7; i++) send(i == 0, 5000, 0);
    for (int i = 0; i < 16; i++) fr[i] = 32'(3 * i + 1);
    send_frame(0);
    check("sof_err_cnt", ecnt - e0, 1);
    wait_res("sof_restart", v0, 46, 15, 9);

    // Missing SOF at frame 1 bin 0: error, back to IDLE, no result
    cfg_avg_log2 = 1;
    v0 = vcnt; e0 = ecnt;
    send_frame(0);
    send(1'b0, 77, 0);
    repeat (3) tick();
    check("nosof_err_cnt", ecnt - e0, 1);
    send(1'b0, 88, 0);
    repeat (30) tick();
    check("nosof_idle_drop", ecnt - e0, 1);
    check("nosof_no_vld", vcnt - v0, 0);

    // Valid held high through SCAN/DONE: nothing accepted
    for (int i = 0; i < 16; i++) fr[i] = 32'(i);
    fr[2] = 900;
    cfg_avg_log2 = 0; in_thr = 10;
    v0 = vcnt;
    send_frame(0);
    a0 = acnt;
    in_valid = 1'b1; in_sof = 1'b0; in_pwr = 32'h00FF_FFFF;
    repeat (17) tick();
    in_valid = 1'b0;
    check("bp_no_accept", acnt - a0, 0);
    wait_res("bp", v0, 900, 2, 6);

    // Reset in the middle of SCAN
    v0 = vcnt;
    send_frame(0);
    repeat (5) tick();
    greset = 1'b1;
    #1;
    check("midrst_pwr", out_peak_pwr, 0);
    check("midrst_idx", out_peak_idx, 0);
    check("midrst_ready", in_ready, 1);
    tick();
    greset = 1'b0;
    repeat (30) tick();
    check("midrst_no_vld", vcnt - v0, 0);
    for (int i = 0; i < 16; i++) fr[i] = 32'(20 * i);
    in_thr = 200;
    send_frame(1);
    wait_res("postrst", v0, 300, 15, 5);

    // Threshold latched at SCAN entry
    for (int i = 0; i < 16; i++) fr[i] = 32'(10 * i);
    in_thr = 100;
    v0 = vcnt;
    send_frame(0);
    tick();
    in_thr = 0;
    wait_res("thr_latch", v0, 150, 15, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
